ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-host arbiter placed directly upstream of one port of the dual-port 32-bit RAM.
- Lets two requesters share one RAM port, e.g. instruction fetch and debug/DMA on port A.
- Grants one request per cycle using round-robin, and drives the RAM request signals unchanged.
- Tracks which host owns the single outstanding access and returns the RAM's 1-cycle response to that host only.

Parameters:
- Depth, 128, RAM depth in 32-bit words. Used only by the range check.
- NumHosts, 2, number of hosts. Fixed at 2; any other value is an elaboration error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- h_req_i  in  2  per-host request, index 0 = host A, 1 = host B
- h_we_i  in  2  per-host write enable
- h_be_i  in  2x4  per-host byte enables
- h_addr_i  in  2x32  per-host byte address
- h_wdata_i  in  2x32  per-host write data
- h_gnt_o  out  2  per-host grant (combinational, same cycle)
- h_rvalid_o  out  2  per-host response valid
- h_rdata_o  out  2x32  per-host read data
- h_err_o  out  2  per-host error, qualified by h_rvalid_o
- ram_req_o  out  1  to RAM req
- ram_we_o  out  1  to RAM we
- ram_be_o  out  4  to RAM be
- ram_addr_o  out  32  to RAM addr
- ram_wdata_o  out  32  to RAM wdata
- ram_rvalid_i  in  1  from RAM rvalid
- ram_rdata_i  in  32  from RAM rdata

Behaviour:
- Reset: synchronous active-low on clk_i.
- Registers: prio_q (1 bit, host with priority), own_q (1 bit, owner of last issued access), pend_q (1 bit, access in flight), err_q (1 bit).
- Reset values: prio_q=0 (host A), pend_q=0, err_q=0.
- Outputs during and right after reset: all h_rvalid_o=0, h_err_o=0, h_rdata_o=0, ram_req_o=0 while rst_ni=0.
- Arbitration, combinational:
  - One host requesting: that host wins.
  - Both requesting: host prio_q wins.
  - h_gnt_o[w]=1 only for the winner; ram_req_o=|h_req_i (forced 0 during reset).
  - ram_* fields are muxed from the winner. ram_wdata_o/ram_be_o are don't-care when ram_we_o=0 but are still the winner's values.
- Priority update:
  - When both hosts request, prio_q <= ~winner at clock edge.
  - When a single host is granted, prio_q <= ~that host.
  - When there is no request, prio_q holds.
- Issue: on each granted cycle, own_q <= winner and pend_q <= 1. With no grant, pend_q <= 0.
- Latency: response arrives exactly one cycle after grant, matching RAM behaviour.
  - h_rvalid_o[own_q] = ram_rvalid_i & pend_q; the other host's h_rvalid_o=0.
  - Reads and writes both get a response.
  - Back-to-back grants (one per cycle) are supported with full throughput.
- Read data: h_rdata_o[own_q] = ram_rdata_i when valid, otherwise 0. The non-owner's data is always 0.
- Error: h_err_o[own_q] = err_q & h_rvalid_o[own_q].
- Unsolicited RAM response: ram_rvalid_i while pend_q=0 is ignored, with no host output.
  - Includes the first cycle after reset release when a pre-reset access completes.
- Hold rule: host request fields are sampled only in the grant cycle. A losing host keeps req high and is granted in a later cycle. A host must not change fields while ungranted; this is asserted.
- Starvation bound: a continuously requesting host is granted within 2 cycles.

Optional Feature:
- Macro: RAM_PORT_ARBITER_RANGE_CHECK_EN
- Enabled:
  - A request with h_addr_i >= Depth*4 is still granted, but ram_req_o=0 for that cycle (the RAM is not accessed).
  - pend_q=1, own_q set, err_q <= 1.
  - Next cycle the owner sees h_rvalid_o=1 (internally generated, not from ram_rvalid_i), h_err_o=1, h_rdata_o=0.
  - In-range grants set err_q <= 0.
- Disabled: err_q is constant 0, h_err_o is always 0, and addresses pass through unchecked; the RAM ignores upper address bits.

Test Plan:
- Only A requests, read at 0x10, RAM returns 0xDEADBEEF -> gnt[0]=1 in cycle 0; rvalid[0]=1, rdata[0]=0xDEADBEEF in cycle 1; rvalid[1]=0.
- Both request for 4 cycles from reset -> grants A,B,A,B; each rvalid lands one cycle after its grant on the right host.
- B writes 0xCAFEF00D at 0x20 with be=4'b0011, then A reads 0x20 -> ram_be_o=0011 in the write cycle; A's read data shows low half 0xF00D.
- Reset asserted in the cycle after a grant, with ram_rvalid_i=1 -> no h_rvalid_o asserted; prio_q back to A, pend_q=0.
- With the macro on, Depth=128: A reads 0x200 -> ram_req_o=0; next cycle rvalid[0]=1, err[0]=1, rdata[0]=0. A following read at 0x1FC gives err[0]=0.
- Unsolicited ram_rvalid_i=1 pulse with no prior grant -> both h_rvalid_o stay 0.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between two RAM hosts, the port arbiter and one RAM port.
// The arbiter connects through the slave modport. The environment (hosts
// plus RAM) drives the bundle through the master modport.
interface ram_port_arbiter_if;

  // Host side: request fields in, grant and response out
  logic [1:0]        h_req_i;
  logic [1:0]        h_we_i;
  logic [1:0][3:0]   h_be_i;
  logic [1:0][31:0]  h_addr_i;
  logic [1:0][31:0]  h_wdata_i;
  logic [1:0]        h_gnt_o;
  logic [1:0]        h_rvalid_o;
  logic [1:0][31:0]  h_rdata_o;
  logic [1:0]        h_err_o;

  // RAM side: single request port out, 1-cycle response in
  logic              ram_req_o;
  logic              ram_we_o;
  logic [3:0]        ram_be_o;
  logic [31:0]       ram_addr_o;
  logic [31:0]       ram_wdata_o;
  logic              ram_rvalid_i;
  logic [31:0]       ram_rdata_i;

  modport slave (
    input  h_req_i, h_we_i, h_be_i, h_addr_i, h_wdata_i,
    input  ram_rvalid_i, ram_rdata_i,
    output h_gnt_o, h_rvalid_o, h_rdata_o, h_err_o,
    output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output h_req_i, h_we_i, h_be_i, h_addr_i, h_wdata_i,
    output ram_rvalid_i, ram_rdata_i,
    input  h_gnt_o, h_rvalid_o, h_rdata_o, h_err_o,
    input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// Two-host round-robin arbiter in front of one port of a 32-bit RAM.
// The arbiter grants one access per cycle and remembers which host owns
// the access in flight. It routes the RAM's 1-cycle response back to that
// host only.
// Optional feature: define RAM_PORT_ARBITER_RANGE_CHECK_EN to enable the
// address range check. When it is enabled, an access beyond Depth words
// is granted but never reaches the RAM. The owner then receives an
// internally generated error response.
module ram_port_arbiter #(
  parameter int Depth    = 128,
  parameter int NumHosts = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ram_port_arbiter_if.slave  bus
);

  // The datapath is hard-wired for exactly two hosts
  if (NumHosts != 2) begin : g_bad_num_hosts
    $error("ram_port_arbiter: NumHosts must be 2");
  end

  if (Depth < 1 || Depth > (1 << 29)) begin : g_bad_depth
    $error("ram_port_arbiter: Depth out of supported range");
  end

  // prio_q: host that wins a tie. own_q: owner of the access in flight.
  // pend_q: an access was issued last cycle. err_q: that access was rejected.
  logic prio_q;
  logic own_q;
  logic pend_q;
  logic err_q;

  logic both_req;
  logic grant_valid;
  logic winner;
  logic range_err;
  logic rsp_valid;

  // Round-robin winner selection: a lone requester always wins, and ties go to prio_q
  always_comb begin
    both_req    = bus.h_req_i[0] & bus.h_req_i[1];
    grant_valid = (|bus.h_req_i) & rst_ni;
    if (both_req) begin
      winner = prio_q;
    end else if (bus.h_req_i[1]) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

`ifdef RAM_PORT_ARBITER_RANGE_CHECK_EN
  localparam logic [31:0] AddrLimit = 32'(Depth * 4);

  // Flag winning requests that address beyond the end of the RAM
  always_comb begin
    range_err = grant_valid && (bus.h_addr_i[winner] >= AddrLimit);
  end
`else
  // Without the range check every address passes through to the RAM unchanged
  always_comb begin
    range_err = 1'b0;
  end
`endif

  // Grant strobe and RAM request mux, driven from the winner's fields
  always_comb begin
    bus.h_gnt_o = 2'b00;
    if (grant_valid) begin
      bus.h_gnt_o[winner] = 1'b1;
    end
    bus.ram_req_o   = grant_valid & ~range_err;
    bus.ram_we_o    = bus.h_we_i[winner];
    bus.ram_be_o    = bus.h_be_i[winner];
    bus.ram_addr_o  = bus.h_addr_i[winner];
    bus.ram_wdata_o = bus.h_wdata_i[winner];
  end

  // Rotate priority after each grant and record the owner of the issued access
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
      own_q  <= 1'b0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= grant_valid;
      if (grant_valid) begin
        prio_q <= ~winner;
        own_q  <= winner;
        err_q  <= range_err;
      end
    end
  end

  // Steer the response to the owner only; rejected accesses answer internally with zero data
  always_comb begin
    rsp_valid      = pend_q & rst_ni & (err_q | bus.ram_rvalid_i);
    bus.h_rvalid_o = 2'b00;
    bus.h_err_o    = 2'b00;
    bus.h_rdata_o  = '0;
    if (rsp_valid) begin
      bus.h_rvalid_o[own_q] = 1'b1;
      bus.h_err_o[own_q]    = err_q;
      bus.h_rdata_o[own_q]  = err_q ? 32'h0 : bus.ram_rdata_i;
    end
  end

  // A host that requests and loses must keep its request up with unchanged fields
  for (genvar h = 0; h < 2; h++) begin : g_hold_rule
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus.h_req_i[h] && !bus.h_gnt_o[h]) |=>
        (bus.h_req_i[h] && $stable(bus.h_we_i[h]) && $stable(bus.h_be_i[h]) &&
         $stable(bus.h_addr_i[h]) && $stable(bus.h_wdata_i[h])));
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter. It includes a 1-cycle RAM model.
// The stimulus pushes each hand-computed response into a queue. A negedge
// monitor pops an entry and compares it whenever a host response is valid.
module tb_ram_port_arbiter;

  localparam int Depth = 128;

  logic clk_i = 1'b0;
  logic rst_ni;

  ram_port_arbiter_if bus ();

  ram_port_arbiter #(.Depth(Depth), .NumHosts(2)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        host;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // RAM model: one-cycle response, byte-enabled writes, word index from addr[8:2]
  logic [31:0] mem [0:Depth-1];
  logic        load_mem      = 1'b1;
  logic        ram_rvalid    = 1'b0;
  logic [31:0] ram_rdata     = 32'h0;
  logic        inject_rvalid = 1'b0;
  logic [6:0]  ram_idx;

  assign ram_idx          = bus.ram_addr_o[8:2];
  assign bus.ram_rvalid_i = ram_rvalid | inject_rvalid;
  assign bus.ram_rdata_i  = ram_rdata;

  // RAM contents and response generation
  always @(posedge clk_i) begin
    ram_rvalid <= bus.ram_req_o;
    ram_rdata  <= 32'h0;
    if (load_mem) begin
      for (int i = 0; i < Depth; i++) mem[i] <= 32'h0;
      mem[0]   <= 32'h0BADC0DE;
      mem[4]   <= 32'hDEADBEEF;
      mem[5]   <= 32'h12345678;
      mem[127] <= 32'hA5A55A5A;
    end else if (bus.ram_req_o) begin
      if (bus.ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_be_o[b]) mem[ram_idx][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_idx];
      end
    end
  end

  rsp_t mon_exp;
  logic mon_host;

  // Monitor: every valid host response must match the oldest expected entry
  always @(negedge clk_i) begin
    if (bus.h_rvalid_o != 2'b00) begin
      checks++;
      if (bus.h_rvalid_o == 2'b11) begin
        failures++;
        $display("[TB] FAIL rsp_onehot actual rvalid=%b required one host only", bus.h_rvalid_o);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL rsp_unexpected actual rvalid=%b required none", bus.h_rvalid_o);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_host = bus.h_rvalid_o[1];
        if (mon_host !== mon_exp.host || bus.h_rdata_o[mon_host] !== mon_exp.data ||
            bus.h_err_o[mon_host] !== mon_exp.err || bus.h_rdata_o[!mon_host] !== 32'h0) begin
          failures++;
          $display("[TB] FAIL rsp_match actual host=%0d data=%h err=%b other_data=%h required host=%0d data=%h err=%b other_data=0",
                   mon_host, bus.h_rdata_o[mon_host], bus.h_err_o[mon_host], bus.h_rdata_o[!mon_host],
                   mon_exp.host, mon_exp.data, mon_exp.err);
        end
      end
    end
  end

  task automatic set_host(input int h, input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.h_req_i[h]   = req;
    bus.h_we_i[h]    = we;
    bus.h_be_i[h]    = be;
    bus.h_addr_i[h]  = addr;
    bus.h_wdata_i[h] = wdata;
  endtask

  task automatic idle_hosts();
    set_host(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_host(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic expect_rsp(input logic host, input logic [31:0] data, input logic err);
    rsp_t r;
    r.host = host;
    r.data = data;
    r.err  = err;
    exp_q.push_back(r);
  endtask

  task automatic do_reset();
    idle_hosts();
    rst_ni = 1'b0;
    repeat (2) next_cycle();
    rst_ni = 1'b1;
  endtask

  logic [1:0] exp_gnt [5];

  // Directed stimulus with hand-computed expectations
  initial begin
    rst_ni        = 1'b0;
    inject_rvalid = 1'b0;
    idle_hosts();
    next_cycle();
    load_mem = 1'b0;

    $display("[TB] reset: request and RAM rvalid held during reset");
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    inject_rvalid = 1'b1;
    @(negedge clk_i);
    check_output("reset_rvalid", 32'(bus.h_rvalid_o), 32'h0);
    check_output("reset_err", 32'(bus.h_err_o), 32'h0);
    check_output("reset_rdata_a", bus.h_rdata_o[0], 32'h0);
    check_output("reset_ram_req", 32'(bus.ram_req_o), 32'h0);
    next_cycle();

    $display("[TB] unsolicited RAM response right after reset release");
    rst_ni = 1'b1;
    idle_hosts();
    @(negedge clk_i);
    check_output("unsolicited_rvalid", 32'(bus.h_rvalid_o), 32'h0);
    next_cycle();
    inject_rvalid = 1'b0;

    $display("[TB] host A alone reads 0x10");
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge clk_i);
    check_output("a_read_gnt", 32'(bus.h_gnt_o), 32'h1);
    check_output("a_read_ram_req", 32'(bus.ram_req_o), 32'h1);
    check_output("a_read_ram_addr", bus.ram_addr_o, 32'h10);
    check_output("a_read_ram_we", 32'(bus.ram_we_o), 32'h0);
    expect_rsp(1'b0, 32'hDEADBEEF, 1'b0);
    next_cycle();
    idle_hosts();
    @(negedge clk_i);
    check_output("a_read_rvalid", 32'(bus.h_rvalid_o), 32'h1);
    check_output("a_read_rdata_b", bus.h_rdata_o[1], 32'h0);
    next_cycle();

    $display("[TB] both hosts request after reset");
    do_reset();
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
    exp_gnt[3] = 2'b10; exp_gnt[4] = 2'b01;
    for (int i = 0; i < 5; i++) begin
      set_host(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      if (i < 4) set_host(1, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
      else       set_host(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk_i);
      check_output($sformatf("rr_gnt_%0d", i), 32'(bus.h_gnt_o), 32'(exp_gnt[i]));
      if (exp_gnt[i] == 2'b01) expect_rsp(1'b0, 32'hDEADBEEF, 1'b0);
      else                     expect_rsp(1'b1, 32'h12345678, 1'b0);
      next_cycle();
    end
    idle_hosts();
    next_cycle();

    $display("[TB] host B partial write, then host A reads it back");
    set_host(1, 1'b1, 1'b1, 4'b0011, 32'h20, 32'hCAFEF00D);
    @(negedge clk_i);
    check_output("b_write_gnt", 32'(bus.h_gnt_o), 32'h2);
    check_output("b_write_ram_we", 32'(bus.ram_we_o), 32'h1);
    check_output("b_write_ram_be", 32'(bus.ram_be_o), 32'h3);
    check_output("b_write_ram_wdata", bus.ram_wdata_o, 32'hCAFEF00D);
    expect_rsp(1'b1, 32'h0, 1'b0);
    next_cycle();
    idle_hosts();
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    @(negedge clk_i);
    check_output("a_readback_gnt", 32'(bus.h_gnt_o), 32'h1);
    expect_rsp(1'b0, 32'h0000F00D, 1'b0);
    next_cycle();
    idle_hosts();
    next_cycle();

    $display("[TB] reset in the cycle after a grant");
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
    @(negedge clk_i);
    check_output("pre_reset_gnt", 32'(bus.h_gnt_o), 32'h1);
    next_cycle();
    idle_hosts();
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_output("reset_ram_rvalid_seen", 32'(bus.ram_rvalid_i), 32'h1);
    check_output("reset_mid_rvalid", 32'(bus.h_rvalid_o), 32'h0);
    next_cycle();
    rst_ni = 1'b1;
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    set_host(1, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0);
    @(negedge clk_i);
    check_output("post_reset_rvalid", 32'(bus.h_rvalid_o), 32'h0);
    check_output("post_reset_prio_gnt", 32'(bus.h_gnt_o), 32'h1);
    expect_rsp(1'b0, 32'hDEADBEEF, 1'b0);
    next_cycle();
    set_host(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_i);
    check_output("post_reset_b_gnt", 32'(bus.h_gnt_o), 32'h2);
    expect_rsp(1'b1, 32'h12345678, 1'b0);
    next_cycle();
    idle_hosts();
    next_cycle();

    $display("[TB] address 0x200 beyond the RAM, then last word 0x1FC");
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    @(negedge clk_i);
    check_output("oor_gnt", 32'(bus.h_gnt_o), 32'h1);
`ifdef RAM_PORT_ARBITER_RANGE_CHECK_EN
    check_output("oor_ram_req", 32'(bus.ram_req_o), 32'h0);
    expect_rsp(1'b0, 32'h0, 1'b1);
`else
    check_output("oor_ram_req", 32'(bus.ram_req_o), 32'h1);
    check_output("oor_ram_addr", bus.ram_addr_o, 32'h200);
    expect_rsp(1'b0, 32'h0BADC0DE, 1'b0);
`endif
    next_cycle();
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h1FC, 32'h0);
    @(negedge clk_i);
    check_output("last_word_ram_req", 32'(bus.ram_req_o), 32'h1);
    expect_rsp(1'b0, 32'hA5A55A5A, 1'b0);
    next_cycle();
    idle_hosts();
    repeat (3) next_cycle();

    check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
